i2c_target_regfile: RTL and testbench

- Clocked I2C target (slave) with an internal byte register file; the downstream partner of i2c_master on the shared SCL/SDA bus.
- Oversamples SCL/SDA on the system clock, detects START/STOP, and matches a 7-bit address.
- Supports pointer-based multi-byte write and read with auto-increment.
- Exposes a local read port and a write-strobe so system logic can consume bytes written by the master.

---
 rtl/i2c_target_regfile.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_i2c_target_regfile.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regfile.sv
`default_nettype none
// ============================================================================
// Module   : i2c_target_regfile
// Purpose  : Clocked I2C target with an internal byte register file.
//            Oversamples SCL/SDA, detects START/STOP, matches a 7-bit
//            address and supports pointer-based multi-byte write and read
//            with auto-increment.
// Ports    : clk, reset (async, active-high)
//            scl_in, sda_in - asynchronous bus levels
//            sda_oe         - 1 pulls SDA low (open-drain)
//            rd_addr/rd_data - local combinational read port
//            wr_strobe/wr_addr/wr_data - one-clk notice of a bus write
//            busy           - address-matched transfer in progress
// Revision : 1.0 - initial release
// ============================================================================
module i2c_target_regfile #(
    parameter logic [6:0] SLAVE_ADDR = 7'h55,
    parameter int         DEPTH      = 16,
    parameter int         PTR_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             scl_in,
    input  logic             sda_in,
    output logic             sda_oe,
    input  logic [PTR_W-1:0] rd_addr,
    output logic [7:0]       rd_data,
    output logic             wr_strobe,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data,
    output logic             busy
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8
    } state_t;

    localparam logic [3:0]       c_BITS_DONE = 4'd8;
    localparam logic [3:0]       c_LAST_BIT  = 4'd7;
    localparam logic [PTR_W-1:0] c_PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Input conditioning: 2-flop synchronizers plus previous value.
    // Reset to 1 so an idle bus produces no spurious edges.
    // ------------------------------------------------------------------
    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_prev_q;
    logic       sda_prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_in};
            sda_sync_q <= {sda_sync_q[0], sda_in};
            scl_prev_q <= scl_sync_q[1];
            sda_prev_q <= sda_sync_q[1];
        end
    end

    logic w_scl;
    logic w_sda;
    logic w_rise;
    logic w_fall;
    logic w_start;
    logic w_stop;

    assign w_scl   = scl_sync_q[1];
    assign w_sda   = sda_sync_q[1];
    assign w_rise  = w_scl & ~scl_prev_q;
    assign w_fall  = ~w_scl & scl_prev_q;
    // SDA moving while SCL is held high marks a bus condition.
    assign w_start = w_scl & scl_prev_q & sda_prev_q & ~w_sda;
    assign w_stop  = w_scl & scl_prev_q & ~sda_prev_q & w_sda;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [6:0]       shift_q, shift_d;
    logic [7:0]       tx_q, tx_d;
    logic             rw_q, rw_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             sda_oe_q, sda_oe_d;
    logic             busy_q, busy_d;
    logic             wr_strobe_q, wr_strobe_d;
    logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic [7:0]       regs_q [DEPTH];
    logic [7:0]       regs_d [DEPTH];

    logic [7:0] w_rx_byte;
    logic [7:0] w_load;
    logic       w_rx_bit;
    logic       w_rx_last;
    logic       w_ack_slot;

    // Byte as it stands once the bit on the current rising edge is included.
    assign w_rx_byte  = {shift_q, w_sda};
    assign w_load     = regs_q[ptr_q];
    assign w_rx_bit   = w_rise && (cnt_q != c_BITS_DONE);
    assign w_rx_last  = w_rise && (cnt_q == c_LAST_BIT);
    // All 8 bits received: the following fall opens the ACK slot.
    assign w_ack_slot = w_fall && (cnt_q == c_BITS_DONE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        rw_d        = rw_q;
        ptr_d       = ptr_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        regs_d      = regs_q;

        if (w_stop) begin
            state_d  = ST_IDLE;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (w_start) begin
            state_d = ST_ADDR;
            cnt_d   = 4'd0;
        end else begin
            // Shared receive shifter for address, pointer and write data.
            if ((state_q == ST_ADDR || state_q == ST_PTR || state_q == ST_WDATA) && w_rx_bit) begin
                shift_d = w_rx_byte[6:0];
                cnt_d   = cnt_q + 4'd1;
            end

            case (state_q)
                ST_IDLE: begin
                    sda_oe_d = 1'b0;
                end
                ST_ADDR: begin
                    if (w_rx_last) begin
                        if (w_rx_byte[7:1] == SLAVE_ADDR) begin
                            busy_d = 1'b1;
                            rw_d   = w_rx_byte[0];
                        end else begin
                            state_d = ST_IDLE;
                            cnt_d   = 4'd0;
                            busy_d  = 1'b0;
                        end
                    end else if (w_ack_slot) begin
                        sda_oe_d = 1'b1;
                        state_d  = ST_ADDR_ACK;
                    end
                end
                ST_ADDR_ACK: begin
                    if (w_fall) begin
                        if (!rw_q) begin
                            sda_oe_d = 1'b0;
                            cnt_d    = 4'd0;
                            state_d  = ST_PTR;
                        end else begin
                            // First read bit goes out on the ACK-ending fall.
                            sda_oe_d = ~w_load[7];
                            tx_d     = {w_load[6:0], 1'b0};
                            cnt_d    = 4'd1;
                            state_d  = ST_RDATA;
                        end
                    end
                end
                ST_PTR: begin
                    if (w_rx_last) begin
                        ptr_d = w_rx_byte[PTR_W-1:0];
                    end else if (w_ack_slot) begin
                        sda_oe_d = 1'b1;
                        state_d  = ST_PTR_ACK;
                    end
                end
                ST_PTR_ACK: begin
                    if (w_fall) begin
                        sda_oe_d = 1'b0;
                        cnt_d    = 4'd0;
                        state_d  = ST_WDATA;
                    end
                end
                ST_WDATA: begin
                    if (w_rx_last) begin
                        regs_d[ptr_q] = w_rx_byte;
                        wr_strobe_d   = 1'b1;
                        wr_addr_d     = ptr_q;
                        wr_data_d     = w_rx_byte;
                        ptr_d         = ptr_q + c_PTR_ONE;
                    end else if (w_ack_slot) begin
                        sda_oe_d = 1'b1;
                        state_d  = ST_WDATA_ACK;
                    end
                end
                ST_WDATA_ACK: begin
                    if (w_fall) begin
                        sda_oe_d = 1'b0;
                        cnt_d    = 4'd0;
                        state_d  = ST_WDATA;
                    end
                end
                ST_RDATA: begin
                    // cnt counts bits already placed on the bus.
                    if (w_fall) begin
                        if (cnt_q != c_BITS_DONE) begin
                            sda_oe_d = ~tx_q[7];
                            tx_d     = {tx_q[6:0], 1'b0};
                            cnt_d    = cnt_q + 4'd1;
                        end else begin
                            sda_oe_d = 1'b0;
                            ptr_d    = ptr_q + c_PTR_ONE;
                            cnt_d    = 4'd0;
                            state_d  = ST_RDATA_ACK;
                        end
                    end
                end
                ST_RDATA_ACK: begin
                    // cnt=1 records that the master ACKed on this slot.
                    if (w_rise) begin
                        if (w_sda) begin
                            state_d  = ST_IDLE;
                            sda_oe_d = 1'b0;
                            busy_d   = 1'b0;
                        end else begin
                            cnt_d = 4'd1;
                        end
                    end else if (w_fall && (cnt_q == 4'd1)) begin
                        sda_oe_d = ~w_load[7];
                        tx_d     = {w_load[6:0], 1'b0};
                        cnt_d    = 4'd1;
                        state_d  = ST_RDATA;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                    busy_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            shift_q     <= 7'd0;
            tx_q        <= 8'd0;
            rw_q        <= 1'b0;
            ptr_q       <= '0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 8'd0;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= 8'd0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            rw_q        <= rw_d;
            ptr_q       <= ptr_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            regs_q      <= regs_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign busy      = busy_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    // Reads the register array directly, so a same-cycle bus write shows
    // up one clk later.
    assign rd_data   = regs_q[rd_addr];

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_target_regfile
// Purpose  : Self-checking bench for i2c_target_regfile. A bit-banged bus
//            master drives directed and randomized transfers; a register
//            array / pointer model predicts ACKs, read bytes, write strobes
//            and local read-port contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_target_regfile;

    localparam logic [6:0] c_ADDR = 7'h55;
    localparam int         c_Q    = 5;   // quarter SCL period in clk cycles

    logic       clk = 1'b0;
    logic       reset;
    logic       scl;
    logic       m_sda;
    logic       sda_line;
    logic       sda_oe;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       wr_strobe;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    assign sda_line = m_sda & ~sda_oe;

    i2c_target_regfile #(
        .SLAVE_ADDR (c_ADDR),
        .DEPTH      (16),
        .PTR_W      (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: register contents and pointer.
    logic [7:0]  m_regs [16];
    logic [3:0]  m_ptr;
    logic [7:0]  tx_bytes [$];
    logic [11:0] wr_seen [$];
    logic [11:0] wr_exp [$];
    logic        watch_oe = 1'b0;
    logic        oe_seen  = 1'b0;
    logic        oe_prev  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: collect write strobes, watch SDA activity, and require that
    // sda_oe only ever moves while SCL is low.
    always @(negedge clk) begin
        if (wr_strobe) wr_seen.push_back({wr_addr, wr_data});
        if (watch_oe && sda_oe) oe_seen = 1'b1;
        if (!reset && (sda_oe !== oe_prev)) check("oe_change_scl_low", scl, 1'b0);
        oe_prev = sda_oe;
    end

    // One SCL clock: set data in the low phase, sample in the high phase.
    task automatic bit_cycle(input logic b, output logic s);
        tick(c_Q); m_sda = b;
        tick(c_Q); scl = 1'b1;
        tick(c_Q); s = sda_line;
        tick(c_Q); scl = 1'b0;
    endtask

    task automatic start_cond();
        tick(c_Q); m_sda = 1'b1;
        tick(c_Q); scl = 1'b1;
        tick(c_Q); m_sda = 1'b0;
        tick(c_Q); scl = 1'b0;
    endtask

    task automatic stop_cond();
        tick(c_Q); m_sda = 1'b0;
        tick(c_Q); scl = 1'b1;
        tick(c_Q); m_sda = 1'b1;
        tick(c_Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
        bit_cycle(1'b1, s);
        ack = ~s;
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, s);
            b[i] = s;
        end
        bit_cycle(~mack, s);
    endtask

    task automatic compare_wr();
        logic [11:0] got;
        logic [11:0] exp;
        check("wr_count", wr_seen.size(), wr_exp.size());
        while (wr_seen.size() > 0 && wr_exp.size() > 0) begin
            got = wr_seen.pop_front();
            exp = wr_exp.pop_front();
            check("wr_event", got, exp);
        end
        wr_seen.delete();
        wr_exp.delete();
    endtask

    task automatic check_regs();
        for (int i = 0; i < 16; i++) begin
            rd_addr = i[3:0];
            #1;
            check("rd_data", rd_data, m_regs[i]);
        end
    endtask

    // Write transfer: address, pointer byte, then every byte in tx_bytes.
    task automatic do_write(input logic [6:0] addr, input logic [7:0] pb);
        logic ack;
        logic match;
        match    = (addr == c_ADDR);
        watch_oe = ~match;
        oe_seen  = 1'b0;
        start_cond();
        send_byte({addr, 1'b0}, ack);
        check("wr_addr_ack", ack, match);
        check("busy_after_addr", busy, match);
        send_byte(pb, ack);
        check("wr_ptr_ack", ack, match);
        if (match) m_ptr = pb[3:0];
        foreach (tx_bytes[i]) begin
            send_byte(tx_bytes[i], ack);
            check("wr_data_ack", ack, match);
            if (match) begin
                m_regs[m_ptr] = tx_bytes[i];
                wr_exp.push_back({m_ptr, tx_bytes[i]});
                m_ptr = m_ptr + 4'd1;
            end
        end
        stop_cond();
        check("busy_after_stop", busy, 1'b0);
        check("oe_quiet_on_mismatch", oe_seen & ~match, 1'b0);
        watch_oe = 1'b0;
        compare_wr();
    endtask

    // Read transfer of n bytes, optionally preceded by a pointer write and
    // a repeated START. Master ACKs all but the last byte.
    task automatic do_read(input logic with_ptr, input logic [7:0] pb, input int n);
        logic       ack;
        logic [7:0] b;
        start_cond();
        if (with_ptr) begin
            send_byte({c_ADDR, 1'b0}, ack);
            check("rd_waddr_ack", ack, 1'b1);
            send_byte(pb, ack);
            check("rd_ptr_ack", ack, 1'b1);
            m_ptr = pb[3:0];
            start_cond();
        end
        send_byte({c_ADDR, 1'b1}, ack);
        check("rd_addr_ack", ack, 1'b1);
        for (int i = 0; i < n; i++) begin
            recv_byte(i != n - 1, b);
            check("rd_byte", b, m_regs[m_ptr]);
            m_ptr = m_ptr + 4'd1;
        end
        check("oe_after_nack", sda_oe, 1'b0);
        check("busy_after_nack", busy, 1'b0);
        stop_cond();
        compare_wr();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] ab;
        logic [6:0] ra;
        int         op;
        int         n;

        reset   = 1'b1;
        scl     = 1'b1;
        m_sda   = 1'b1;
        rd_addr = 4'd0;
        m_ptr   = 4'd0;
        for (int i = 0; i < 16; i++) m_regs[i] = 8'd0;
        tick(3);
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_wr_strobe", wr_strobe, 1'b0);
        check("rst_wr_addr", wr_addr, 4'd0);
        check("rst_wr_data", wr_data, 8'd0);
        check("rst_rd_data", rd_data, 8'd0);
        reset = 1'b0;
        tick(5);

        // Pointer 2, three data bytes, then confirm the pointer sits at 5.
        tx_bytes = '{8'h11, 8'h22, 8'h33};
        do_write(c_ADDR, 8'h02);
        check_regs();
        do_read(1'b0, 8'h00, 1);

        // Pointer write, repeated START, three-byte read.
        do_read(1'b1, 8'h02, 3);

        // Address mismatch with two data bytes.
        tx_bytes = '{8'hDE, 8'hAD};
        do_write(7'h54, 8'h03);
        check_regs();

        // Pointer wrap at the top of the file.
        tx_bytes = '{8'h5A, 8'hA5};
        do_write(c_ADDR, 8'h0F);
        check_regs();
        do_read(1'b0, 8'h00, 1);

        // STOP in the middle of a data byte.
        tx_bytes.delete();
        do_write(c_ADDR, 8'h07);
        start_cond();
        send_byte({c_ADDR, 1'b0}, ack);
        check("part_addr_ack", ack, 1'b1);
        send_byte(8'h07, ack);
        check("part_ptr_ack", ack, 1'b1);
        for (int i = 0; i < 4; i++) bit_cycle(i[0], s);
        stop_cond();
        check("part_busy", busy, 1'b0);
        check("part_oe", sda_oe, 1'b0);
        compare_wr();
        do_read(1'b0, 8'h00, 2);

        // Reset while the target is holding the address ACK.
        ab = {c_ADDR, 1'b0};
        start_cond();
        for (int i = 7; i >= 0; i--) bit_cycle(ab[i], s);
        tick(4);
        check("ack_oe_before_reset", sda_oe, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_oe", sda_oe, 1'b0);
        check("async_reset_busy", busy, 1'b0);
        scl   = 1'b1;
        m_sda = 1'b1;
        for (int i = 0; i < 16; i++) m_regs[i] = 8'd0;
        m_ptr = 4'd0;
        check_regs();
        tick(2);
        reset = 1'b0;
        tick(5);
        wr_seen.delete();
        tx_bytes = '{8'hC3};
        do_write(c_ADDR, 8'h03);
        check_regs();
        do_read(1'b0, 8'h00, 1);

        // Randomized transfers against the model.
        for (int it = 0; it < 16; it++) begin
            op = $urandom_range(0, 3);
            n  = $urandom_range(1, 4);
            tx_bytes.delete();
            for (int k = 0; k < n; k++) tx_bytes.push_back(8'($urandom));
            case (op)
                0: do_write(c_ADDR, 8'($urandom));
                1: do_read(1'b1, 8'($urandom), n);
                2: do_read(1'b0, 8'h00, n);
                default: begin
                    ra = 7'($urandom);
                    if (ra == c_ADDR) ra = ra ^ 7'h01;
                    do_write(ra, 8'($urandom));
                end
            endcase
        end
        check_regs();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
